// File: rtl/ahblite_ir_tx_pkg.sv
// ---------------------------------------------------------------------------
// Module   : ir_tx_pkg
// Purpose  : State encoding, NEC unit counts and register offsets for the IR transmitter.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ir_tx_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4,
    REP_SPACE  = 3'd5,
    STOP_MARK  = 3'd6
  } ir_state_e;

  localparam int REM_W = 5;

  localparam logic [REM_W-1:0] LEAD_MARK_UNITS  = 5'd16;
  localparam logic [REM_W-1:0] LEAD_SPACE_UNITS = 5'd8;
  localparam logic [REM_W-1:0] REP_SPACE_UNITS  = 5'd4;
  localparam logic [REM_W-1:0] BIT_MARK_UNITS   = 5'd1;
  localparam logic [REM_W-1:0] ONE_SPACE_UNITS  = 5'd3;
  localparam logic [REM_W-1:0] ZERO_SPACE_UNITS = 5'd1;
  localparam logic [REM_W-1:0] STOP_UNITS       = 5'd1;

  localparam logic [31:0] DATA_OFS   = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;

  function automatic logic is_mark(input ir_state_e s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahblite_ir_tx_if.sv
// ---------------------------------------------------------------------------
// Module   : ahblite_ir_tx_if
// Purpose  : AHB-Lite slave-side bundle for the IR transmitter.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ahblite_ir_tx_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

`default_nettype wire

// File: rtl/ahblite_ir_tx_carrier_gen.sv
// ---------------------------------------------------------------------------
// Module   : ir_carrier_gen
// Purpose  : Carrier phase counter with duty compare; held at zero while restart is high.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ir_carrier_gen #(
  parameter int CARR_DIV = 1316,
  parameter int CARR_ON  = 439
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic restart_i,
  output logic carrier_o
);

  localparam int CW = $clog2(CARR_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(CARR_DIV - 1);
  localparam logic [CW-1:0] C_ON   = CW'(CARR_ON);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carrier_o = en_i && (cnt_q < C_ON);

endmodule

`default_nettype wire

// File: rtl/ahblite_ir_tx.sv
// ---------------------------------------------------------------------------
// Module   : ahblite_ir_tx
// Purpose  : AHB-Lite NEC infrared transmitter; IR_TX_REPEAT_EN adds repeat frames.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahblite_ir_tx
  import ir_tx_pkg::*;
#(
  parameter int UNIT_CYCLES = 28125,
  parameter int CARR_DIV    = 1316,
  parameter int CARR_ON     = 439
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahblite_ir_tx_if.slave   ahb,
  output logic             ir_tx_out,
  output logic             ir_tx_irq
);

  localparam int UW = $clog2(UNIT_CYCLES);
  localparam logic [UW-1:0] C_UNIT_LAST = UW'(UNIT_CYCLES - 1);

  logic             wr_q, rd_q, ofs_q;
  ir_state_e        state_q;
  logic [UW-1:0]    unit_q;
  logic [REM_W-1:0] rem_q;
  logic [5:0]       bit_q;
  logic [7:0]       addr_q, cmd_q;
  logic             rep_q, irq_q, done_q, err_q;

  logic             addr_ok, data_wr, stat_wr, busy, start, err_set;
  logic             unit_wrap, last_unit, rep_req, mark;
  logic [31:0]      frame_bits;
  logic [REM_W-1:0] space_units;
  logic [31:0]      hrdata;
  logic             unused_bus;

  // Address phase: remember offset and direction for the following data phase.
  assign addr_ok = ahb.HSEL && ahb.HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      ofs_q <= 1'b0;
    end else if (ahb.HREADY) begin
      wr_q  <= addr_ok && ahb.HWRITE;
      rd_q  <= addr_ok && !ahb.HWRITE;
      ofs_q <= ahb.HADDR[2];
    end
  end

  assign busy    = (state_q != IDLE);
  assign data_wr = wr_q && (ofs_q == DATA_OFS[2]);
  assign stat_wr = wr_q && (ofs_q == STATUS_OFS[2]);
  assign start   = data_wr && !busy;
  assign err_set = data_wr && busy;

`ifdef IR_TX_REPEAT_EN
  assign rep_req = ahb.HWDATA[31];
`else
  assign rep_req = 1'b0;
`endif

  // Sent LSB first: addr, ~addr, cmd, ~cmd.
  assign frame_bits  = {~cmd_q, cmd_q, ~addr_q, addr_q};
  assign space_units = frame_bits[bit_q[4:0]] ? ONE_SPACE_UNITS : ZERO_SPACE_UNITS;
  assign unit_wrap   = (unit_q == C_UNIT_LAST);
  assign last_unit   = unit_wrap && (rem_q == REM_W'(1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      unit_q  <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
      addr_q  <= '0;
      cmd_q   <= '0;
      rep_q   <= 1'b0;
      irq_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (stat_wr && ahb.HWDATA[1]) done_q <= 1'b0;
      if (stat_wr && ahb.HWDATA[2]) err_q  <= 1'b0;
      if (err_set)                  err_q  <= 1'b1;

      if (state_q == IDLE) begin
        unit_q <= '0;
        if (start) begin
          state_q <= LEAD_MARK;
          rem_q   <= LEAD_MARK_UNITS;
          bit_q   <= '0;
          rep_q   <= rep_req;
          if (!rep_req) begin
            addr_q <= ahb.HWDATA[15:8];
            cmd_q  <= ahb.HWDATA[7:0];
          end
        end
      end else begin
        unit_q <= unit_wrap ? '0 : unit_q + UW'(1);
        if (unit_wrap && !last_unit) rem_q <= rem_q - REM_W'(1);

        case (state_q)
          LEAD_MARK: if (last_unit) begin
            if (rep_q) begin
              state_q <= REP_SPACE;
              rem_q   <= REP_SPACE_UNITS;
            end else begin
              state_q <= LEAD_SPACE;
              rem_q   <= LEAD_SPACE_UNITS;
            end
          end
          LEAD_SPACE: if (last_unit) begin
            state_q <= BIT_MARK;
            rem_q   <= BIT_MARK_UNITS;
            bit_q   <= '0;
          end
          BIT_MARK: if (last_unit) begin
            state_q <= BIT_SPACE;
            rem_q   <= space_units;
          end
          BIT_SPACE: if (last_unit) begin
            if (bit_q == 6'd31) begin
              state_q <= STOP_MARK;
              rem_q   <= STOP_UNITS;
            end else begin
              state_q <= BIT_MARK;
              rem_q   <= BIT_MARK_UNITS;
              bit_q   <= bit_q + 6'd1;
            end
          end
          REP_SPACE: if (last_unit) begin
            state_q <= STOP_MARK;
            rem_q   <= STOP_UNITS;
          end
          STOP_MARK: if (last_unit) begin
            state_q <= IDLE;
            irq_q   <= 1'b1;
            done_q  <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Carrier phase sits at zero outside marks, so every mark entry starts high.
  assign mark = is_mark(state_q);

  ir_carrier_gen #(
    .CARR_DIV (CARR_DIV),
    .CARR_ON  (CARR_ON)
  ) u_carrier (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .en_i      (mark),
    .restart_i (!mark),
    .carrier_o (ir_tx_out)
  );

  assign ir_tx_irq = irq_q;

  always_comb begin
    hrdata = '0;
    if (rd_q) begin
      hrdata = ofs_q ? {29'b0, err_q, done_q, busy} : {16'b0, addr_q, cmd_q};
    end
  end

  assign ahb.HRDATA    = hrdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

  assign unused_bus = ^{ahb.HADDR[31:3], ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HSIZE,
                        ahb.HPROT, ahb.HWDATA[31:16]};

endmodule

`default_nettype wire

// File: tb/tb_ahblite_ir_tx.sv
// ---------------------------------------------------------------------------
// Module   : tb_ahblite_ir_tx
// Purpose  : Self-checking bench for ahblite_ir_tx against a segment-list NEC waveform model.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ahblite_ir_tx;

  localparam int UNIT_CYCLES = 12;
  localparam int CARR_DIV    = 4;
  localparam int CARR_ON     = 2;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic ir_tx_out, ir_tx_irq;

  ahblite_ir_tx_if ahb();

  ahblite_ir_tx #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .CARR_DIV    (CARR_DIV),
    .CARR_ON     (CARR_ON)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .ahb       (ahb),
    .ir_tx_out (ir_tx_out),
    .ir_tx_irq (ir_tx_irq)
  );

  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference waveform: list of (mark?, length in cycles) segments.
  bit seg_mark[$];
  int seg_len[$];

  function automatic void push_seg(input bit m, input int units);
    seg_mark.push_back(m);
    seg_len.push_back(units * UNIT_CYCLES);
  endfunction

  function automatic void build_frame(input logic [7:0] a, input logic [7:0] c, input bit rep);
    logic [31:0] w;
    seg_mark.delete();
    seg_len.delete();
    push_seg(1'b1, 16);
    if (rep) begin
      push_seg(1'b0, 4);
    end else begin
      push_seg(1'b0, 8);
      w = {~c, c, ~a, a};
      for (int i = 0; i < 32; i++) begin
        push_seg(1'b1, 1);
        push_seg(1'b0, w[i] ? 3 : 1);
      end
    end
    push_seg(1'b1, 1);
  endfunction

  function automatic int frame_len();
    int t = 0;
    foreach (seg_len[i]) t += seg_len[i];
    return t;
  endfunction

  function automatic logic exp_out(input int k);
    int t = 0;
    foreach (seg_len[i]) begin
      if (k < t + seg_len[i]) return seg_mark[i] && (((k - t) % CARR_DIV) < CARR_ON);
      t += seg_len[i];
    end
    return 1'b0;
  endfunction

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge HCLK); #1;
    ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b1; ahb.HADDR = addr;
    @(posedge HCLK); #1;
    ahb.HSEL = 1'b0; ahb.HTRANS = 2'b00; ahb.HWRITE = 1'b0; ahb.HWDATA = data;
    @(negedge HCLK);
    check("hrdata_in_write", ahb.HRDATA, 32'h0);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge HCLK); #1;
    ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b0; ahb.HADDR = addr;
    @(posedge HCLK); #1;
    ahb.HSEL = 1'b0; ahb.HTRANS = 2'b00;
    @(negedge HCLK);
    data = ahb.HRDATA;
  endtask

  // Must be called right after the DATA write that starts the frame.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input bit rep, input int extra);
    int n;
    build_frame(a, c, rep);
    n = frame_len();
    @(posedge HCLK);
    for (int k = 0; k < n + extra; k++) begin
      @(negedge HCLK);
      check("ir_tx_out", ir_tx_out, exp_out(k));
      check("ir_tx_irq", ir_tx_irq, (k == n));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  a, c, a2, c2;
    int          n;

    ahb.HSEL = 1'b0; ahb.HADDR = '0; ahb.HTRANS = 2'b00; ahb.HSIZE = 3'b010;
    ahb.HPROT = 4'b0011; ahb.HWRITE = 1'b0; ahb.HWDATA = '0; ahb.HREADY = 1'b1;

    // Reset state
    repeat (3) begin
      @(negedge HCLK);
      check("rst_out", ir_tx_out, 1'b0);
      check("rst_irq", ir_tx_irq, 1'b0);
    end
    @(posedge HCLK); #1 HRESETn = 1'b1;
    ahb_read(32'h0, rd); check("rst_data", rd, 32'h0);
    ahb_read(32'h4, rd); check("rst_status", rd, 32'h0);
    check("hreadyout", ahb.HREADYOUT, 1'b1);
    check("hresp", ahb.HRESP, 1'b0);
    check("idle_out", ir_tx_out, 1'b0);

    // Fixed frame addr 0x00 cmd 0xFF
    ahb_write(32'h0, 32'h0000_00FF);
    run_frame(8'h00, 8'hFF, 1'b0, 4);
    ahb_read(32'h4, rd); check("status_done", rd, 32'h2);
    ahb_read(32'h0, rd); check("data_rb", rd, 32'h00FF);
    ahb_write(32'h4, 32'h2);
    ahb_read(32'h4, rd); check("status_clr_done", rd, 32'h0);

    // Write while busy is ignored and flags err
    a = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255));
    if ({a, c} == 16'h1234) c = c ^ 8'h01;
    ahb_write(32'h0, {16'h0, a, c});
    fork
      run_frame(a, c, 1'b0, 4);
      begin
        repeat (100) @(posedge HCLK);
        ahb_write(32'h0, 32'h0000_1234);
        ahb_read(32'h4, rd); check("status_busy_err", rd, 32'h5);
      end
    join
    ahb_read(32'h4, rd); check("status_err_done", rd, 32'h6);
    ahb_read(32'h0, rd); check("data_unchanged", rd, {16'h0, a, c});
    ahb_write(32'h4, 32'h6);
    ahb_read(32'h4, rd); check("status_clr_both", rd, 32'h0);

    // Reset in the middle of a frame
    a = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255));
    ahb_write(32'h0, {16'h0, a, c});
    @(posedge HCLK);
    repeat (500) @(posedge HCLK);
    #3 HRESETn = 1'b0;
    #1;
    check("midrst_out", ir_tx_out, 1'b0);
    check("midrst_irq", ir_tx_irq, 1'b0);
    repeat (3) begin
      @(negedge HCLK);
      check("midrst_out_hold", ir_tx_out, 1'b0);
      check("midrst_irq_hold", ir_tx_irq, 1'b0);
    end
    @(posedge HCLK); #1 HRESETn = 1'b1;
    ahb_read(32'h4, rd); check("midrst_status", rd, 32'h0);
    ahb_read(32'h0, rd); check("midrst_data", rd, 32'h0);
    a = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255));
    ahb_write(32'h0, {16'h0, a, c});
    run_frame(a, c, 1'b0, 2);
    ahb_read(32'h4, rd); check("post_rst_done", rd, 32'h2);
    ahb_write(32'h4, 32'h2);

    // Back-to-back: next DATA write has its data phase in the cycle after irq
    a  = 8'($urandom_range(0, 255));
    c  = 8'($urandom_range(0, 255));
    a2 = 8'($urandom_range(0, 255));
    c2 = 8'($urandom_range(0, 255));
    ahb_write(32'h0, {16'h0, a, c});
    build_frame(a, c, 1'b0);
    n = frame_len();
    fork
      run_frame(a, c, 1'b0, 1);
      begin
        repeat (n) @(posedge HCLK);
        ahb_write(32'h0, {16'h0, a2, c2});
      end
    join
    run_frame(a2, c2, 1'b0, 3);
    ahb_read(32'h4, rd); check("b2b_status", rd, 32'h2);
    ahb_read(32'h0, rd); check("b2b_data", rd, {16'h0, a2, c2});
    ahb_write(32'h4, 32'h2);

`ifdef IR_TX_REPEAT_EN
    // Repeat frame keeps the previous addr/cmd
    ahb_write(32'h0, 32'h8000_0000);
    run_frame(a2, c2, 1'b1, 3);
    ahb_read(32'h0, rd); check("rep_data_unchanged", rd, {16'h0, a2, c2});
    ahb_read(32'h4, rd); check("rep_status", rd, 32'h2);
`else
    // Bit 31 is ignored: a full frame with the written fields
    a = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255));
    ahb_write(32'h0, {16'h8000, a, c});
    run_frame(a, c, 1'b0, 3);
    ahb_read(32'h0, rd); check("bit31_data", rd, {16'h0, a, c});
    ahb_read(32'h4, rd); check("bit31_status", rd, 32'h2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
